// File: rtl/mem_arb_2to1_wide.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_2to1_wide
// Description : Two-requester round-robin arbiter in front of a single wide
//               line-refill memory port. One transaction in flight at a time,
//               sequenced by a three-state FSM (IDLE -> REQ -> DONE).
//
// Ports       : clk, reset           - clock, synchronous active-high reset
//               sN_req_valid/addr    - requester N refill request and address
//               sN_req_ready/rdata   - one-cycle data-valid pulse and line data
//               mem_req_valid/addr   - downstream request, held until ready
//               mem_req_ready/rdata  - downstream one-cycle data-valid pulse
//               s0_grant_count, s1_grant_count, conflict_count
//                                    - statistics counters, present only
//                                      when MEM_ARB_STATS_EN is defined
//
// Macro       : MEM_ARB_STATS_EN - adds the grant/conflict statistics outputs
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_2to1_wide #(
   parameter int NUM_BLOCKS = 4
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     s0_req_valid,
   output logic                     s0_req_ready,
   input  logic [31:0]              s0_req_addr,
   output logic [32*NUM_BLOCKS-1:0] s0_req_rdata,

   input  logic                     s1_req_valid,
   output logic                     s1_req_ready,
   input  logic [31:0]              s1_req_addr,
   output logic [32*NUM_BLOCKS-1:0] s1_req_rdata,

   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [31:0]              mem_req_addr,
   input  logic [32*NUM_BLOCKS-1:0] mem_req_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]              s0_grant_count,
   output logic [31:0]              s1_grant_count,
   output logic [31:0]              conflict_count
`endif
);

   localparam int DATA_W = 32 * NUM_BLOCKS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic                grant_q;      // 0: port 0 owns the transaction, 1: port 1
   logic                last_q;       // most recently granted port
   logic                abandon_q;    // grantee dropped valid at some point in REQ
   logic                mem_valid_q;
   logic [31:0]         mem_addr_q;
   logic                s0_ready_q;
   logic                s1_ready_q;
   logic [DATA_W-1:0]   s0_rdata_q;
   logic [DATA_W-1:0]   s1_rdata_q;

   logic                pick1_d;      // arbitration result: 1 selects port 1
   logic                any_valid_d;
   logic                grantee_valid_d;

   // Port 1 wins when it is alone, or when both request and port 0 was the
   // last one served. Reset leaves last_q=1 so port 0 wins the first tie.
   assign any_valid_d     = s0_req_valid | s1_req_valid;
   assign pick1_d         = s1_req_valid & (~s0_req_valid | ~last_q);
   assign grantee_valid_d = grant_q ? s1_req_valid : s0_req_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         abandon_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         s0_ready_q  <= 1'b0;
         s1_ready_q  <= 1'b0;
         s0_rdata_q  <= '0;
         s1_rdata_q  <= '0;
      end else begin
         // Ready outputs are single-cycle pulses; only the REQ completion
         // path raises them.
         s0_ready_q <= 1'b0;
         s1_ready_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (any_valid_d) begin
                  grant_q     <= pick1_d;
                  last_q      <= pick1_d;
                  mem_addr_q  <= pick1_d ? s1_req_addr : s0_req_addr;
                  mem_valid_q <= 1'b1;
                  abandon_q   <= 1'b0;
                  state_q     <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (mem_req_ready) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= ST_DONE;
                  // A requester that let go of valid (now or earlier in this
                  // transaction) no longer wants the data: drop it silently.
                  if (!abandon_q && grantee_valid_d) begin
                     if (grant_q) begin
                        s1_rdata_q <= mem_req_rdata;
                        s1_ready_q <= 1'b1;
                     end else begin
                        s0_rdata_q <= mem_req_rdata;
                        s0_ready_q <= 1'b1;
                     end
                  end
               end else if (!grantee_valid_d) begin
                  abandon_q <= 1'b1;
               end
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req_valid = mem_valid_q;
   assign mem_req_addr  = mem_addr_q;
   assign s0_req_ready  = s0_ready_q;
   assign s1_req_ready  = s1_ready_q;
   assign s0_req_rdata  = s0_rdata_q;
   assign s1_req_rdata  = s1_rdata_q;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] s0_cnt_q;
   logic [31:0] s1_cnt_q;
   logic [31:0] conf_cnt_q;

   // Counters wrap naturally on overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_cnt_q   <= '0;
         s1_cnt_q   <= '0;
         conf_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
         if (any_valid_d && !pick1_d) begin
            s0_cnt_q <= s0_cnt_q + 32'd1;
         end
         if (pick1_d) begin
            s1_cnt_q <= s1_cnt_q + 32'd1;
         end
         if (s0_req_valid && s1_req_valid) begin
            conf_cnt_q <= conf_cnt_q + 32'd1;
         end
      end
   end

   assign s0_grant_count = s0_cnt_q;
   assign s1_grant_count = s1_cnt_q;
   assign conflict_count = conf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/mem_arb_2to1_wide.md
MEM_ARB_2TO1_WIDE -- requirements
Module: mem_arb_2to1_wide

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4, words per refill line; rdata width is 32*NUM_BLOCKS.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s0_req_valid  input  1  requester 0 refill request; held high until served or abandoned.
REQ-005 SHALL have port s0_req_ready  output  1  one-cycle pulse: s0_req_rdata valid.
REQ-006 SHALL have port s0_req_addr  input  32  requester 0 line address.
REQ-007 SHALL have port s0_req_rdata  output  32*NUM_BLOCKS  requester 0 line data.
REQ-008 SHALL have ports s1_req_valid, s1_req_ready, s1_req_addr, s1_req_rdata, identical to REQ-004..007 for requester 1.
REQ-009 SHALL have port mem_req_valid  output  1  downstream request, held until mem_req_ready.
REQ-010 SHALL have port mem_req_ready  input  1  one-cycle pulse: mem_req_rdata valid.
REQ-011 SHALL have port mem_req_addr  output  32  granted request address.
REQ-012 SHALL have port mem_req_rdata  input  32*NUM_BLOCKS  downstream line data.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, REQ, DONE.
REQ-014 IDLE: if any sN_req_valid is high, SHALL latch grantee and its address, go to REQ; else stay.
REQ-015 Arbitration SHALL be round-robin: single valid wins; both valid -> port not most recently granted wins.
REQ-016 REQ: mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the latched address for the whole state.
REQ-017 REQ with mem_req_ready=1: SHALL register mem_req_rdata into grantee's sN_req_rdata, pulse grantee's sN_req_ready for exactly the next cycle, clear mem_req_valid, go to DONE.
REQ-018 DONE: SHALL last exactly one cycle, ignore both valid inputs, then go to IDLE.
REQ-019 Latency: valid seen in IDLE at cycle 0 -> mem_req_valid=1 at cycle 1; mem_req_ready at cycle k -> sN_req_ready=1 at cycle k+1; next grant decision at cycle k+2 earliest.
REQ-020 Grantee dropping valid during REQ (abandon) SHALL NOT cancel the downstream transaction; the arbiter SHALL hold mem_req_valid until mem_req_ready, discard data, pulse no ready, and proceed via DONE.
REQ-021 Non-granted port's sN_req_rdata SHALL hold its previous value; sN_req_ready SHALL stay 0.
REQ-022 mem_req_ready while in IDLE or DONE SHALL be ignored.
REQ-023 Round-robin pointer SHALL update only on grant (REQ-014), including grants later abandoned.
REQ-024 Address change on granted sN_req_addr during REQ SHALL NOT affect mem_req_addr.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, mem_req_valid=0, s0_req_ready=0, s1_req_ready=0, mem_req_addr=0, both sN_req_rdata=0, round-robin pointer favouring port 0.
REQ-027 Reset during REQ SHALL abandon the transaction with no ready pulse; a later mem_req_ready SHALL be ignored per REQ-022.

Configuration
REQ-028 Macro MEM_ARB_STATS_EN defined: SHALL add outputs s0_grant_count, s1_grant_count, conflict_count (32 bits each, reset 0, wrap on overflow); grant counts increment per grant, conflict_count when both valid in an IDLE cycle.
REQ-029 MEM_ARB_STATS_EN undefined: those ports and counters SHALL not exist; behaviour otherwise identical.

Verification
REQ-030 Single request: s0 valid, addr 0x0000_1230, memory ready 3 cycles after mem_req_valid, rdata 0xA5.. -> mem_req_addr=0x0000_1230, s0_req_ready pulse 1 cycle after mem ready, s0_req_rdata=0xA5.., s1 untouched.
REQ-031 Contention: s0 and s1 valid same cycle from reset -> s0 served first, then s1; next simultaneous pair -> s0 served first again (s1 last granted).
REQ-032 Back-to-back: s1 reasserts valid after its ready while s0 idle -> DONE gap of one cycle, second mem_req_valid rises at cycle k+3.
REQ-033 Abandon: s0 drops valid 1 cycle into REQ -> mem_req_valid held to mem ready, no s0_req_ready pulse, s0_req_rdata unchanged.
REQ-034 Reset mid-REQ: reset pulsed during REQ, then mem_req_ready -> all outputs 0, no ready pulse, FSM IDLE.
REQ-035 With MEM_ARB_STATS_EN: 3 contended pairs plus 2 solo s1 requests -> s0_grant_count=3, s1_grant_count=5, conflict_count=3.
